dma_controller: RTL and testbench
=================================

// Module: dma_controller
// PURPOSE
//  Single-channel memory-to-memory DMA engine for the 32-byte bus memory.
//  Copies len bytes from src_addr to dst_addr over the shared 8-bit address/data bus.
//  Gets bus ownership from the CPU through a hold/hlda handshake.
//  Sequences the memory's control line: 1 = memory drives databus (read), 0 = memory writes on posedge clk.
// PARAMETERS
//  ADDR_W     8      address bus width
//  DATA_W     8      data bus width
//  MEM_DEPTH  32     number of valid memory locations (0..MEM_DEPTH-1)
//  IDLE_ADDR  8'hFF  address driven when idle; outside the memory range, so the memory is deselected
// PORTS
//  clk         in     1       system clock, all state on rising edge
//  rst_n       in     1       asynchronous active-low reset
//  start       in     1       one-cycle request; sampled only in IDLE
//  src_addr    in     ADDR_W  first source address, captured on start
//  dst_addr    in     ADDR_W  first destination address, captured on start
//  len         in     ADDR_W  byte count, captured on start
//  hold        out    1       bus request to CPU
//  hlda        in     1       bus grant from CPU
//  busy        out    1       high from accepted start until DONE exits
//  done        out    1       one-cycle completion pulse
//  err         out    1       one-cycle pulse, coincident with done, on range error
//  addressbus  out    ADDR_W  memory address
//  control     out    1       1 = read, 0 = write
//  databus     inout  DATA_W  driven only in WRITE state, else 'z
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; hold=0, busy=0, done=0, err=0.
//   Also addressbus=IDLE_ADDR, control=1, databus='z. These values apply immediately, mid-transfer included.
//  addressbus, control and databus come from state/pointer registers only. No combinational path from inputs.
//  control is never 0 outside WRITE, so the memory sees no write outside WRITE.
//  States: IDLE, REQ, READ, WRITE, DONE.
//  IDLE: on start, capture src/dst/len into src_ptr, dst_ptr, cnt.
//   len==0 -> DONE, no hold.
//   Range check: src_addr+len > MEM_DEPTH or dst_addr+len > MEM_DEPTH, computed at ADDR_W+1 bits.
//   Range error -> DONE with err flag set, no hold.
//   Otherwise -> REQ, busy=1.
//  REQ: hold=1; stays until hlda=1, then -> READ.
//  READ: addressbus=src_ptr, control=1. On posedge, data_r <= databus.
//   If hlda=0 on that edge, discard the sample and go to REQ; pointers stay unchanged.
//   Otherwise -> WRITE.
//  WRITE: addressbus=dst_ptr, control=0, databus=data_r. The memory writes on posedge.
//   On the same edge: src_ptr++, dst_ptr++, cnt--.
//   WRITE always completes, even if hlda drops.
//   Next state: cnt==1 -> DONE; else if hlda=0 -> REQ; else -> READ.
//  DONE: hold=0, done=1 (and err=1 if flagged) for exactly one cycle, then IDLE with busy=0.
//  start while busy is ignored. start is not queued.
//  Throughput: 2 cycles/byte. With hlda already high, done is high in cycle 2*len+2 after the start edge.
//  Copies run forward only. Overlapping regions with dst>src give replicated data; this is the defined behaviour.
// STRUCTURE
//  Shared include dma_defs.vh holds:
//   - state encoding localparams (IDLE=0, REQ=1, READ=2, WRITE=3, DONE=4)
//   - MEM_DEPTH, IDLE_ADDR
//  Sub-module dma_addr_gen holds src_ptr/dst_ptr/cnt: load on start, step on WRITE, last = (cnt==1).
//  dma_controller holds the FSM, the data_r latch and the tristate driver.
// TESTING (memory preloaded mem[i]=i)
//  1 Reset: rst_n=0 -> addressbus=8'hFF, control=1, databus z, hold/busy/done=0; mem unchanged.
//  2 src=0, dst=16, len=4, hlda tied high -> mem[16..19]=0,1,2,3; done in cycle 10; all other locations unchanged.
//  3 len=0 -> done one cycle after start; hold never asserted; no write cycle.
//  4 src=30, len=4 -> err=done=1 for one cycle; hold never asserted; mem unchanged.
//  5 src=4, dst=20, len=3; hlda low for 3 cycles after the first WRITE.
//    -> hold stays 1; control stays 1 while ungranted; transfer resumes; mem[20..22]=4,5,6.
//  6 rst_n pulsed low during the second WRITE of scenario 2 -> outputs return to reset values at once.
//    Only mem[16] and, at most, mem[17] are modified.

Source files
------------

// File: rtl/dma_controller_pkg.sv
// Shared types and defaults for the single-channel memory-to-memory DMA engine.
// Replaces the old dma_defs.vh include: state encoding plus memory geometry.
package dma_controller_pkg;

    localparam int          DMA_ADDR_W    = 8;
    localparam int          DMA_DATA_W    = 8;
    localparam int          DMA_MEM_DEPTH = 32;
    localparam logic [7:0]  DMA_IDLE_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dma_controller_if.sv
// Bus-side signals of the DMA engine: CPU hold/hlda handshake plus memory address/control.
interface dma_controller_if #(
    parameter int ADDR_W = 8
) ();

    logic              hold;
    logic              hlda;
    logic [ADDR_W-1:0] addressbus;
    logic              control;

    modport master (output hold, output addressbus, output control, input hlda);
    modport slave  (input hold, input addressbus, input control, output hlda);

endinterface

// File: rtl/dma_controller_addr_gen.sv
// Source/destination pointers and remaining byte count for the DMA engine.
module dma_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [ADDR_W-1:0] len_in,
    output logic [ADDR_W-1:0] src_ptr,
    output logic [ADDR_W-1:0] dst_ptr,
    output logic              last
);

    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
        end else if (load) begin
            src_ptr <= src_in;
            dst_ptr <= dst_in;
            cnt     <= len_in;
        end else if (step) begin
            src_ptr <= src_ptr + ADDR_W'(1);
            dst_ptr <= dst_ptr + ADDR_W'(1);
            cnt     <= cnt - ADDR_W'(1);
        end
    end

    assign last = (cnt == ADDR_W'(1));

endmodule

// File: rtl/dma_controller.sv
// Single-channel memory-to-memory DMA: obtains the bus via hold/hlda, then copies
// len bytes with alternating READ/WRITE cycles on the shared address/data bus.
module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int                ADDR_W    = DMA_ADDR_W,
    parameter int                DATA_W    = DMA_DATA_W,
    parameter int                MEM_DEPTH = DMA_MEM_DEPTH,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(DMA_IDLE_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              err,
    inout  wire  [DATA_W-1:0] databus,
    dma_controller_if.master  bus
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state, state_n;
    logic              load, step, last;
    logic              err_f;
    logic              range_err;
    logic [ADDR_W:0]   src_end, dst_end;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [DATA_W-1:0] data_r;

    // One extra bit so that e.g. 250+10 does not wrap into the valid range.
    assign src_end   = {1'b0, src_addr} + {1'b0, len};
    assign dst_end   = {1'b0, dst_addr} + {1'b0, len};
    assign range_err = (src_end > DEPTH_LIM) || (dst_end > DEPTH_LIM);

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .src_in  (src_addr),
        .dst_in  (dst_addr),
        .len_in  (len),
        .src_ptr (src_ptr),
        .dst_ptr (dst_ptr),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = ((len == '0) || range_err) ? DONE : REQ;
                end
            end
            REQ:   if (bus.hlda) state_n = READ;
            READ:  state_n = bus.hlda ? WRITE : REQ;
            WRITE: begin
                step = 1'b1;
                if (last)           state_n = DONE;
                else if (!bus.hlda) state_n = REQ;
                else                state_n = READ;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    err_f <= 1'b0;
        else if (load) err_f <= (len != '0) && range_err;
    end

    // A sample taken without grant is dropped; the byte is re-read after REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         data_r <= '0;
        else if (state == READ && bus.hlda) data_r <= databus;
    end

    assign bus.hold       = (state == REQ) || (state == READ) || (state == WRITE);
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign err            = (state == DONE) && err_f;
    assign bus.control    = (state != WRITE);
    assign bus.addressbus = (state == READ)  ? src_ptr :
                            (state == WRITE) ? dst_ptr : IDLE_ADDR;
    assign databus        = (state == WRITE) ? data_r : 'z;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller with a 32-byte bus memory and a transfer-level model.
module tb_dma_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] src_addr, dst_addr, len;
    logic       busy, done, err;
    wire  [7:0] databus;
    logic       mem_init;
    logic [7:0] mem [32];

    dma_controller_if #(.ADDR_W(8)) bus ();

    dma_controller #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .MEM_DEPTH (32),
        .IDLE_ADDR (8'hFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .databus  (databus),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Bus memory: drives data when selected for read, writes on posedge when control=0.
    assign databus = (bus.control && bus.addressbus < 8'd32) ? mem[bus.addressbus[4:0]] : 'z;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
        end else if (!bus.control && bus.addressbus < 8'd32) begin
            mem[bus.addressbus[4:0]] <= databus;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Transfer-level model state
    int mm [32];
    bit xfer_active = 1'b0;
    bit no_hold;
    int exp_err;
    int exp_done_cyc;
    int start_cyc;
    int rd_addr;
    int last_done_cyc;
    int wq_a [$];
    int wq_d [$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic compare_cycle();
        int cur;
        if (!rst_n || mem_init) return;
        cur = cyc - start_cyc + 1;
        if (!xfer_active) begin
            check("idle_outputs",
                  {bus.hold, busy, done, err, bus.control, bus.addressbus},
                  {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF});
        end else begin
            check("busy", busy, 1);
            if (no_hold) check("no_hold", bus.hold, 0);
            if (!bus.control) begin
                if (wq_a.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("wr_addr", bus.addressbus, wq_a.pop_front());
                    check("wr_data", databus, wq_d.pop_front());
                    check("wr_hold", bus.hold, 1);
                    rd_addr++;
                end
            end else if (bus.addressbus != 8'hFF) begin
                check("rd_addr", bus.addressbus, rd_addr);
                check("rd_hold", bus.hold, 1);
            end
            if (done) begin
                check("done_err", err, exp_err);
                check("done_writes_left", wq_a.size(), 0);
                if (exp_done_cyc != 0) check("done_cycle", cur, exp_done_cyc);
                last_done_cyc = cur;
                xfer_active   = 1'b0;
            end else begin
                check("err_without_done", err, 0);
            end
        end
    endtask

    task automatic start_xfer(input int s, input int d, input int l, input bit steady);
        @(negedge clk); #1;
        src_addr = 8'(s);
        dst_addr = 8'(d);
        len      = 8'(l);
        start    = 1'b1;
        no_hold  = 1'b0;
        exp_err  = 0;
        rd_addr  = s;
        wq_a.delete();
        wq_d.delete();
        if (l == 0) begin
            no_hold      = 1'b1;
            exp_done_cyc = 1;
        end else if (s + l > 32 || d + l > 32) begin
            no_hold      = 1'b1;
            exp_err      = 1;
            exp_done_cyc = 1;
        end else begin
            for (int k = 0; k < l; k++) begin
                mm[d + k] = mm[s + k];
                wq_a.push_back(d + k);
                wq_d.push_back(mm[d + k]);
            end
            exp_done_cyc = steady ? 2 * l + 2 : 0;
        end
        xfer_active = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            xfer_active = 1'b0;
        end
        @(negedge clk); #1;
    endtask

    task automatic reinit_mem();
        @(negedge clk); mem_init = 1'b1;
        @(negedge clk); mem_init = 1'b0;
        for (int i = 0; i < 32; i++) mm[i] = i;
    endtask

    task automatic mem_vs_model(input string name);
        int nbad = 0;
        for (int i = 0; i < 32; i++) if (int'(mem[i]) != mm[i]) nbad++;
        check(name, nbad, 0);
    endtask

    initial begin
        int nbad;
        rst_n    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        bus.hlda = 1'b1;
        mem_init = 1'b1;
        for (int i = 0; i < 32; i++) mm[i] = i;

        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_addressbus", bus.addressbus, 8'hFF);
        check("rst_control", bus.control, 1);
        check("rst_hold_busy_done_err", {bus.hold, busy, done, err}, 0);
        @(negedge clk);
        mem_init = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        mem_vs_model("rst_mem_unchanged");

        // Basic copy with grant held high
        start_xfer(0, 16, 4, 1'b1);
        wait_done(40);
        check("s2_latency_literal", last_done_cyc, 10);
        check("s2_mem16", mem[16], 0);
        check("s2_mem17", mem[17], 1);
        check("s2_mem18", mem[18], 2);
        check("s2_mem19", mem[19], 3);
        mem_vs_model("s2_mem_image");

        // Zero length
        start_xfer(5, 6, 0, 1'b1);
        wait_done(10);
        check("s3_latency_literal", last_done_cyc, 1);
        mem_vs_model("s3_mem_image");

        // Source range overflow
        start_xfer(30, 0, 4, 1'b1);
        wait_done(10);
        check("s4_latency_literal", last_done_cyc, 1);
        mem_vs_model("s4_mem_image");

        // Exact fit at the top of memory is legal
        start_xfer(28, 8, 4, 1'b1);
        wait_done(40);
        check("edge_latency", last_done_cyc, 10);
        check("edge_mem8", mem[8], 28);
        mem_vs_model("edge_mem_image");

        // Grant withdrawn after the first write; a start while busy must be ignored
        start_xfer(4, 20, 3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (!bus.control) break;
            @(posedge clk); #1;
        end
        check("s5_first_write_seen", bus.control, 0);
        bus.hlda = 1'b0;
        src_addr = 8'd0;
        dst_addr = 8'd1;
        len      = 8'd1;
        start    = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'b0;
            check("s5_ungranted_hold", bus.hold, 1);
            check("s5_ungranted_control", bus.control, 1);
        end
        bus.hlda = 1'b1;
        wait_done(40);
        check("s5_mem20", mem[20], 4);
        check("s5_mem21", mem[21], 5);
        check("s5_mem22", mem[22], 6);
        mem_vs_model("s5_mem_image");

        // Asynchronous reset in the middle of the second write
        reinit_mem();
        start_xfer(0, 16, 4, 1'b1);
        begin
            int wr_seen = 0;
            for (int i = 0; i < 20 && wr_seen < 2; i++) begin
                if (!bus.control) wr_seen++;
                if (wr_seen < 2) begin
                    @(posedge clk); #1;
                end
            end
            check("s6_second_write_seen", wr_seen, 2);
        end
        rst_n = 1'b0;
        #1;
        xfer_active = 1'b0;
        wq_a.delete();
        wq_d.delete();
        check("s6_addressbus", bus.addressbus, 8'hFF);
        check("s6_control", bus.control, 1);
        check("s6_hold_busy_done_err", {bus.hold, busy, done, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("s6_mem16", mem[16], 0);
        check("s6_mem17", (mem[17] == 8'd17 || mem[17] == 8'd1) ? 1 : 0, 1);
        nbad = 0;
        for (int i = 0; i < 32; i++) if (i != 16 && i != 17 && int'(mem[i]) != i) nbad++;
        check("s6_mem_others", nbad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
